agnus_dma_arbiter: RTL and testbench
====================================

Name: agnus_dma_arbiter

Overview:
Parametrised chip-bus DMA slot arbiter, the generalised successor to the fixed if/else priority chain in Agnus. It accepts N DMA channel requests, each with its own slot-eligibility mask, and grants the bus to at most one channel per bus cycle. Fixed-priority and round-robin tiers are supported, together with a generalised CPU-starvation throttle (blitter-slowdown style). It drives the chip address, register address, dbr, dbwe and cpu_custom outputs, registered one cycle after the decision.

Parameters:
NCH, 8, number of DMA channels; index 0 has the highest fixed priority.
ADDR_W, 20, chip address width (bits ADDR_W:1).
SLOT_MASK, {NCH{4'b1010}}, 4 bits per channel; bit s set means the channel may use slot hpos[1:0]==s.
RR_MASK, 0, set bits mark channels in the lowest, round-robin tier.
THROTTLE_MASK, 0, set bits mark channels blocked when the starvation counter saturates.
STARVE_MAX, 3, starvation counter saturation value (counter width 2..4 bits, sized to fit).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clk7_en  in  1  bus-cycle enable; all state advances only when high
hpos_slot  in  2  current slot, hpos[1:0]
dma_en  in  NCH  per-channel enable (DMACON-derived)
req  in  NCH  per-channel DMA request
addr_in  in  NCH*ADDR_W  flattened channel chip addresses
regaddr_in  in  NCH*8  flattened channel register addresses
we_in  in  NCH  per-channel write flag
cpu_req  in  1  CPU wants chip bus
cpu_pri  in  1  nasty-mode override (bltpri); disables throttling
cpu_reg_address  in  8  CPU register address, passed through when idle
grant  out  NCH  one-hot registered acknowledge
address_out  out  ADDR_W  chip address
reg_address_out  out  8  register address
dbr  out  1  Agnus owns the bus
dbwe  out  1  DMA write cycle
cpu_custom  out  1  CPU owns the bus
starve_cnt  out  w  current starvation count (debug/status)

Behaviour:
- Eligibility: elig[i] = req[i] & dma_en[i] & SLOT_MASK[i*4+hpos_slot] & ~(THROTTLE_MASK[i] & throttled).
- throttled = (starve_cnt==STARVE_MAX) & ~cpu_pri.
- Fixed tier: the lowest-index eligible channel not in RR_MASK wins.
- RR tier: considered only when no fixed-tier channel is eligible. Search starts at rr_ptr and wraps modulo NCH. After an RR grant, rr_ptr <= winner+1 (wraps to 0 after NCH-1). rr_ptr is unchanged on fixed or idle cycles.
- Latency: the decision is combinational from inputs and registered on the clk7_en edge. Outputs are valid for the following bus cycle and hold while clk7_en is low.
- Granted cycle: grant one-hot; address_out/reg_address_out/dbwe from the winner; dbr=1; cpu_custom=0.
- Idle cycle: grant=0, address_out=0, reg_address_out=cpu_reg_address, dbr=0, dbwe=0, cpu_custom=1.
- Starvation counter, updated on clk7_en:
  - cleared when ~cpu_req, cpu_pri, or the CPU owned the decided cycle;
  - incremented when cpu_req is high and the winner is in THROTTLE_MASK;
  - saturates at STARVE_MAX;
  - otherwise held.
- Simultaneous events: clear has precedence over increment. If the CPU is idle and all throttled channels are blocked, the cycle goes to the CPU or to a non-throttled channel, which resets nothing unless the CPU wins.
- Reset (asynchronous, any time, including mid-grant): grant=0, address_out=0, reg_address_out=8'hFF, dbr=0, dbwe=0, cpu_custom=1, starve_cnt=0, rr_ptr=0.
- NCH=1: the RR pointer degenerates to a constant 0.

Decomposition:
- Package agnus_dma_pkg: slot encoding constants (SLOT_CPU0..SLOT_CHIP3), the idle register address 8'hFF, and a function computing the counter width from STARVE_MAX.
- Sub-module agnus_rr_pick: combinational rotating priority picker (NCH, mask, ptr in; one-hot winner and index out). It is instantiated once for the RR tier; the fixed tier uses the same picker with ptr=0.

Test Plan:
- Priority/slot: NCH=4, SLOT_MASK ch0=4'b1000, ch1=4'b1010. req=4'b0011 with slot 3 -> grant=0001 next cycle. Slot 1 -> grant=0010. Slot 0 -> grant=0, cpu_custom=1, reg_address_out=cpu_reg_address.
- Round-robin: RR_MASK=4'b1100, ch2 and ch3 requesting continuously, all slots eligible -> grants alternate 0100, 1000, 0100, … Asserting ch0 for one cycle inserts 0001 with no pointer advance.
- Throttle: THROTTLE_MASK=ch3, STARVE_MAX=3, cpu_req=1, ch3 requesting every cycle -> three ch3 grants, starve_cnt=3, fourth cycle cpu_custom=1, counter clears, ch3 resumes.
- cpu_pri=1 under the same stimulus -> ch3 granted every cycle and starve_cnt stays 0.
- Write path: ch1 we_in=1, addr=20'h1234A -> dbwe=1, address_out=20'h1234A for exactly the granted cycle.
- Async reset: assert reset between edges mid-grant -> outputs immediately at reset values with no clock. After release, the first decision is made with rr_ptr=0.

Source files
------------

// File: rtl/agnus_dma_pkg.sv
// Agnus DMA arbiter shared definitions.
// Slot encoding, idle register address and counter sizing.
package agnus_dma_pkg;

    // hpos[1:0] slot encoding: even slots belong to the CPU, odd to chip DMA
    localparam logic [1:0] SLOT_CPU0  = 2'd0;
    localparam logic [1:0] SLOT_CHIP1 = 2'd1;
    localparam logic [1:0] SLOT_CPU2  = 2'd2;
    localparam logic [1:0] SLOT_CHIP3 = 2'd3;

    // register address driven when no DMA channel owns the bus
    localparam logic [7:0] IDLE_REG = 8'hFF;

    // starvation counter width: fits STARVE_MAX, clamped to 2..4 bits
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 2) w = 2;
        if (w > 4) w = 4;
        return w;
    endfunction

endpackage

// File: rtl/agnus_rr_pick.sv
// Rotating priority picker.
// Finds the first set mask bit starting at ptr, wrapping modulo NCH.
module agnus_rr_pick
    import agnus_dma_pkg::*;
#(
    parameter int NCH = 8,
    parameter int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] mask,
    input  logic [PW-1:0]  ptr,
    output logic [NCH-1:0] onehot,
    output logic [PW-1:0]  idx,
    output logic           valid
);

    // scan NCH positions from ptr, first hit wins
    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            j = int'(ptr) + k;
            if (j >= NCH) j = j - NCH;
            if (!valid && mask[j]) begin
                valid     = 1'b1;
                onehot[j] = 1'b1;
                idx       = PW'(j);
            end
        end
    end

endmodule

// File: rtl/agnus_dma_arbiter.sv
// Chip-bus DMA slot arbiter with fixed and round-robin tiers
// and a CPU-starvation throttle; outputs registered on clk7_en.
module agnus_dma_arbiter
    import agnus_dma_pkg::*;
#(
    parameter int                 NCH           = 8,
    parameter int                 ADDR_W        = 20,
    parameter logic [4*NCH-1:0]   SLOT_MASK     = {NCH{4'b1010}},
    parameter logic [NCH-1:0]     RR_MASK       = '0,
    parameter logic [NCH-1:0]     THROTTLE_MASK = '0,
    parameter int                 STARVE_MAX    = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk7_en,
    input  logic [1:0]              hpos_slot,
    input  logic [NCH-1:0]          dma_en,
    input  logic [NCH-1:0]          req,
    input  logic [NCH*ADDR_W-1:0]   addr_in,
    input  logic [NCH*8-1:0]        regaddr_in,
    input  logic [NCH-1:0]          we_in,
    input  logic                    cpu_req,
    input  logic                    cpu_pri,
    input  logic [7:0]              cpu_reg_address,
    output logic [NCH-1:0]          grant,
    output logic [ADDR_W-1:0]       address_out,
    output logic [7:0]              reg_address_out,
    output logic                    dbr,
    output logic                    dbwe,
    output logic                    cpu_custom,
    output logic [cnt_width(STARVE_MAX)-1:0] starve_cnt
);

    localparam int CW = cnt_width(STARVE_MAX);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    logic [NCH-1:0]    grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        reg_q, reg_d;
    logic              dbr_q, dbr_d;
    logic              dbwe_q, dbwe_d;
    logic              cpu_custom_q, cpu_custom_d;
    logic [CW-1:0]     starve_q, starve_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;

    logic              throttled;
    logic [NCH-1:0]    elig;
    logic [NCH-1:0]    fix_oh, rr_oh;
    logic [PW-1:0]     fix_idx, rr_idx, win_idx;
    logic              fix_valid, rr_valid, win_valid;
    logic [NCH-1:0]    win_oh;

    assign throttled = (starve_q == SMAX) & ~cpu_pri;

    // per-channel eligibility for the current slot
    always_comb begin
        elig = '0;
        for (int i = 0; i < NCH; i++) begin
            elig[i] = req[i] & dma_en[i]
                    & SLOT_MASK[4*i + int'(hpos_slot)]
                    & ~(THROTTLE_MASK[i] & throttled);
        end
    end

    agnus_rr_pick #(.NCH(NCH), .PW(PW)) u_fix_pick (
        .mask   (elig & ~RR_MASK),
        .ptr    ({PW{1'b0}}),
        .onehot (fix_oh),
        .idx    (fix_idx),
        .valid  (fix_valid)
    );

    agnus_rr_pick #(.NCH(NCH), .PW(PW)) u_rr_pick (
        .mask   (elig & RR_MASK),
        .ptr    (rr_ptr_q),
        .onehot (rr_oh),
        .idx    (rr_idx),
        .valid  (rr_valid)
    );

    assign win_valid = fix_valid | rr_valid;
    assign win_oh    = fix_valid ? fix_oh : rr_oh;
    assign win_idx   = fix_valid ? fix_idx : rr_idx;

    // next bus-cycle outputs, pointer and starvation count
    always_comb begin
        grant_d      = win_oh;
        addr_d       = '0;
        reg_d        = cpu_reg_address;
        dbwe_d       = 1'b0;
        dbr_d        = win_valid;
        cpu_custom_d = ~win_valid;
        for (int i = 0; i < NCH; i++) begin
            if (win_oh[i]) begin
                addr_d = addr_in[i*ADDR_W +: ADDR_W];
                reg_d  = regaddr_in[i*8 +: 8];
                dbwe_d = we_in[i];
            end
        end

        rr_ptr_d = rr_ptr_q;
        if (NCH == 1) begin
            rr_ptr_d = '0;
        end else if (!fix_valid && rr_valid) begin
            if (win_idx == PW'(NCH - 1)) rr_ptr_d = '0;
            else                         rr_ptr_d = win_idx + PW'(1);
        end

        starve_d = starve_q;
        if (!cpu_req || cpu_pri || !win_valid) begin
            starve_d = '0;
        end else if (|(win_oh & THROTTLE_MASK)) begin
            if (starve_q != SMAX) starve_d = starve_q + CW'(1);
        end
    end

    // register the decision once per bus cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q      <= '0;
            addr_q       <= '0;
            reg_q        <= IDLE_REG;
            dbr_q        <= 1'b0;
            dbwe_q       <= 1'b0;
            cpu_custom_q <= 1'b1;
            starve_q     <= '0;
            rr_ptr_q     <= '0;
        end else if (clk7_en) begin
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            reg_q        <= reg_d;
            dbr_q        <= dbr_d;
            dbwe_q       <= dbwe_d;
            cpu_custom_q <= cpu_custom_d;
            starve_q     <= starve_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign grant           = grant_q;
    assign address_out     = addr_q;
    assign reg_address_out = reg_q;
    assign dbr             = dbr_q;
    assign dbwe            = dbwe_q;
    assign cpu_custom      = cpu_custom_q;
    assign starve_cnt      = starve_q;

endmodule

// File: tb/tb_agnus_dma_arbiter.sv
// Directed testbench for agnus_dma_arbiter.
// NCH=4: ch0/ch1 fixed tier, ch2/ch3 round-robin, ch3 throttled.
module tb_agnus_dma_arbiter;

    localparam int NCH    = 4;
    localparam int ADDR_W = 20;

    logic                  clk;
    logic                  reset;
    logic                  clk7_en;
    logic [1:0]            hpos_slot;
    logic [NCH-1:0]        dma_en;
    logic [NCH-1:0]        req;
    logic [NCH*ADDR_W-1:0] addr_in;
    logic [NCH*8-1:0]      regaddr_in;
    logic [NCH-1:0]        we_in;
    logic                  cpu_req;
    logic                  cpu_pri;
    logic [7:0]            cpu_reg_address;
    logic [NCH-1:0]        grant;
    logic [ADDR_W-1:0]     address_out;
    logic [7:0]            reg_address_out;
    logic                  dbr;
    logic                  dbwe;
    logic                  cpu_custom;
    logic [1:0]            starve_cnt;

    int errors = 0;
    int checks = 0;

    agnus_dma_arbiter #(
        .NCH           (NCH),
        .ADDR_W        (ADDR_W),
        .SLOT_MASK     ({4'b1111, 4'b1111, 4'b1010, 4'b1000}),
        .RR_MASK       (4'b1100),
        .THROTTLE_MASK (4'b1000),
        .STARVE_MAX    (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .clk7_en         (clk7_en),
        .hpos_slot       (hpos_slot),
        .dma_en          (dma_en),
        .req             (req),
        .addr_in         (addr_in),
        .regaddr_in      (regaddr_in),
        .we_in           (we_in),
        .cpu_req         (cpu_req),
        .cpu_pri         (cpu_pri),
        .cpu_reg_address (cpu_reg_address),
        .grant           (grant),
        .address_out     (address_out),
        .reg_address_out (reg_address_out),
        .dbr             (dbr),
        .dbwe            (dbwe),
        .cpu_custom      (cpu_custom),
        .starve_cnt      (starve_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        clk7_en         = 1'b1;
        hpos_slot       = 2'd0;
        dma_en          = 4'hF;
        req             = '0;
        addr_in         = '0;
        we_in           = '0;
        cpu_req         = 1'b0;
        cpu_pri         = 1'b0;
        cpu_reg_address = 8'h3C;
        regaddr_in      = {8'h13, 8'h12, 8'h11, 8'h10};
        #3;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_addr", 32'(address_out), 32'h0);
        check("rst_reg", 32'(reg_address_out), 32'hFF);
        check("rst_dbr", 32'(dbr), 32'h0);
        check("rst_dbwe", 32'(dbwe), 32'h0);
        check("rst_cpu", 32'(cpu_custom), 32'h1);
        check("rst_cnt", 32'(starve_cnt), 32'h0);
        reset = 1'b0;

        // fixed priority and slot masks
        req = 4'b0011;
        hpos_slot = 2'd3;
        step();
        check("pri_s3_grant", 32'(grant), 32'h1);
        check("pri_s3_dbr", 32'(dbr), 32'h1);
        check("pri_s3_reg", 32'(reg_address_out), 32'h10);
        check("pri_s3_cpu", 32'(cpu_custom), 32'h0);
        hpos_slot = 2'd1;
        step();
        check("pri_s1_grant", 32'(grant), 32'h2);
        check("pri_s1_reg", 32'(reg_address_out), 32'h11);
        hpos_slot = 2'd0;
        step();
        check("pri_s0_grant", 32'(grant), 32'h0);
        check("pri_s0_cpu", 32'(cpu_custom), 32'h1);
        check("pri_s0_reg", 32'(reg_address_out), 32'h3C);
        check("pri_s0_dbr", 32'(dbr), 32'h0);

        // outputs hold while clk7_en is low
        clk7_en = 1'b0;
        hpos_slot = 2'd3;
        step();
        check("hold_grant", 32'(grant), 32'h0);
        check("hold_cpu", 32'(cpu_custom), 32'h1);
        clk7_en = 1'b1;

        // write path
        req = 4'b0010;
        we_in = 4'b0010;
        addr_in[1*ADDR_W +: ADDR_W] = 20'h1234A;
        hpos_slot = 2'd1;
        step();
        check("wr_grant", 32'(grant), 32'h2);
        check("wr_dbwe", 32'(dbwe), 32'h1);
        check("wr_addr", 32'(address_out), 32'h1234A);
        req = 4'b0000;
        step();
        check("wr_after_dbwe", 32'(dbwe), 32'h0);
        check("wr_after_addr", 32'(address_out), 32'h0);
        we_in = '0;

        // round robin with a fixed-tier interruption
        do_reset();
        hpos_slot = 2'd3;
        req = 4'b1100;
        step();
        check("rr_0", 32'(grant), 32'h4);
        step();
        check("rr_1", 32'(grant), 32'h8);
        step();
        check("rr_2", 32'(grant), 32'h4);
        req = 4'b1101;
        step();
        check("rr_ch0", 32'(grant), 32'h1);
        req = 4'b1100;
        step();
        check("rr_3", 32'(grant), 32'h8);
        step();
        check("rr_4", 32'(grant), 32'h4);

        // asynchronous reset mid-grant, rr_ptr is 3 here
        reset = 1'b1;
        #1;
        check("arst_grant", 32'(grant), 32'h0);
        check("arst_reg", 32'(reg_address_out), 32'hFF);
        check("arst_dbr", 32'(dbr), 32'h0);
        check("arst_cpu", 32'(cpu_custom), 32'h1);
        reset = 1'b0;
        step();
        check("arst_first", 32'(grant), 32'h4);

        // starvation throttle
        do_reset();
        req = 4'b1000;
        cpu_req = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            step();
            check("thr_grant", 32'(grant), 32'h8);
            check("thr_cnt", 32'(starve_cnt), 32'(n));
        end
        step();
        check("thr_blk_grant", 32'(grant), 32'h0);
        check("thr_blk_cpu", 32'(cpu_custom), 32'h1);
        check("thr_blk_cnt", 32'(starve_cnt), 32'h0);
        step();
        check("thr_resume", 32'(grant), 32'h8);
        check("thr_resume_cnt", 32'(starve_cnt), 32'h1);

        // nasty mode disables throttling
        do_reset();
        cpu_pri = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            check("pri_grant", 32'(grant), 32'h8);
            check("pri_cnt", 32'(starve_cnt), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
